systolic_array_sequencer: RTL and testbench

- Sequences one matrix job through the systolic array: optionally loads N weight rows, then streams N input rows paired with N partial-sum rows.
- Tracks the N result rows coming back and reports completion.
- Sits between the tensor-core row buffer (valid/ready stream source) and the systolic array memory-side port. It replaces the hand-driven row loads the bench does today.

---
 rtl/systolic_array_pkg.sv | 33 +++
 rtl/systolic_array_sequencer_if.sv | 18 +
 rtl/systolic_array_issue_reg.sv | 61 ++++++
 rtl/systolic_array_sequencer.sv | 152 +++++++++++++++
 tb/tb_systolic_array_sequencer.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_array_pkg.sv
// Shared types and constants for the systolic array sequencer slice.
// N (array dimension, power of two >= 2) and WIDTH (element width) live here,
// so the row type, the stream interface and the sequencer always agree on them.
package systolic_array_pkg;

  localparam int unsigned N         = 4;
  localparam int unsigned WIDTH     = 16;
  localparam int unsigned ROW_IDX_W = $clog2(N);
  localparam int unsigned GAP_W     = 4;  // holds ISSUE_GAP in 0..15

  typedef logic [N*WIDTH-1:0]   row_t;
  typedef logic [ROW_IDX_W-1:0] row_idx_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StLoadIp,
    StWaitOut,
    StDone
  } seq_state_t;

  // One array-port beat as driven for a single cycle.
  typedef struct packed {
    logic     weight_en;
    logic     input_en;
    logic     partial_en;
    row_idx_t row_in;
    row_idx_t row_ps;
    row_t     data;
    row_t     partials;
  } issue_t;

endpackage

// File: rtl/systolic_array_sequencer_if.sv
// Row-buffer stream between the tensor-core row buffer and the sequencer.
//   src_valid   : row buffer has a row
//   src_ready   : sequencer accepts the row this cycle (valid && ready)
//   src_row     : weight row or input row
//   src_partial : partial-sum row, ignored while loading weights
// master = row buffer side, slave = sequencer side.
interface systolic_array_sequencer_if;
  import systolic_array_pkg::*;

  logic src_valid;
  logic src_ready;
  row_t src_row;
  row_t src_partial;

  modport master (output src_valid, output src_row, output src_partial, input src_ready);
  modport slave  (input src_valid, input src_row, input src_partial, output src_ready);

endinterface

// File: rtl/systolic_array_issue_reg.sv
// Registered one-cycle driver for the systolic array memory-side port.
// A beat strobe captures type, row index and data; the port shows the beat on the
// following cycle only and falls back to all zeros unless another beat arrives.
//   beat/is_weight/idx/row/partial : beat request from the sequencer
//   weight_en/input_en/partial_en  : array write enables
//   row_in_en/row_ps_en            : input/weight and partial row indices
//   array_in/array_in_partials     : row data and partial data to the array
module systolic_array_issue_reg
  import systolic_array_pkg::*;
(
  input  logic     clk,
  input  logic     nRST,
  input  logic     beat,
  input  logic     is_weight,
  input  row_idx_t idx,
  input  row_t     row,
  input  row_t     partial,
  output logic     weight_en,
  output logic     input_en,
  output logic     partial_en,
  output row_idx_t row_in_en,
  output row_idx_t row_ps_en,
  output row_t     array_in,
  output row_t     array_in_partials
);

  issue_t issue_d, issue_q;

  always_comb begin
    issue_d = '0;
    if (beat) begin
      issue_d.weight_en  = is_weight;
      issue_d.input_en   = !is_weight;
      issue_d.partial_en = !is_weight;
      issue_d.row_in     = idx;
      issue_d.data       = row;
      // Weight beats carry no partial row; keep that side of the port quiet.
      if (!is_weight) begin
        issue_d.row_ps   = idx;
        issue_d.partials = partial;
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      issue_q <= '0;
    end else begin
      issue_q <= issue_d;
    end
  end

  assign weight_en         = issue_q.weight_en;
  assign input_en          = issue_q.input_en;
  assign partial_en        = issue_q.partial_en;
  assign row_in_en         = issue_q.row_in;
  assign row_ps_en         = issue_q.row_ps;
  assign array_in          = issue_q.data;
  assign array_in_partials = issue_q.partials;

endmodule

// File: rtl/systolic_array_sequencer.sv
// Sequences one matrix job through the systolic array: optional N weight rows,
// then N input rows paired with N partial rows, then waits for N result rows and
// a drained array before pulsing done.
//   clk, nRST                 : clock, asynchronous active-low reset
//   start, load_weights       : job start (IDLE only) and weight-reload select
//   busy, done, err           : job active, completion pulse, sticky result-order error
//   src                       : row-buffer stream (slave side)
//   weight_en .. array_in_partials : registered array write port
//   fifo_has_space, drained   : array input FIFO space, array empty of work
//   out_en, row_out           : result row valid and its index
module systolic_array_sequencer
  import systolic_array_pkg::*;
#(
  parameter int unsigned ISSUE_GAP = 1
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic                       start,
  input  logic                       load_weights,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  systolic_array_sequencer_if.slave  src,
  output logic                       weight_en,
  output logic                       input_en,
  output logic                       partial_en,
  output row_idx_t                   row_in_en,
  output row_idx_t                   row_ps_en,
  output row_t                       array_in,
  output row_t                       array_in_partials,
  input  logic                       fifo_has_space,
  input  logic                       drained,
  input  logic                       out_en,
  input  row_idx_t                   row_out
);

  localparam logic [GAP_W-1:0]   GapLoad = GAP_W'(ISSUE_GAP);
  localparam logic [ROW_IDX_W:0] OutAll  = (ROW_IDX_W + 1)'(N);
  localparam row_idx_t           RowLast = row_idx_t'(N - 1);

  seq_state_t         state_q, state_d;
  row_idx_t           row_cnt_q, row_cnt_d;
  logic [ROW_IDX_W:0] out_cnt_q, out_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               err_q, err_d;
  logic               src_ready;
  logic               accept;
  logic               track;

  // Ready never looks at src_valid so the row buffer can use it to decide.
  always_comb begin
    src_ready = 1'b0;
    case (state_q)
      StLoadW:  src_ready = 1'b1;
      StLoadIp: src_ready = fifo_has_space && (gap_cnt_q == '0);
      default:  src_ready = 1'b0;
    endcase
  end

  assign src.src_ready = src_ready;
  assign accept        = src.src_valid && src_ready;
  // Results can start returning while inputs are still streaming in.
  assign track = out_en && (out_cnt_q != OutAll) &&
                 ((state_q == StLoadIp) || (state_q == StWaitOut));

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    out_cnt_d = out_cnt_q;
    err_d     = err_q;
    gap_cnt_d = (gap_cnt_q != '0) ? gap_cnt_q - 1'b1 : '0;

    if (track) begin
      out_cnt_d = out_cnt_q + 1'b1;
      if (row_out != out_cnt_q[ROW_IDX_W-1:0]) begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = load_weights ? StLoadW : StLoadIp;
          err_d     = 1'b0;
          row_cnt_d = '0;
          out_cnt_d = '0;
          gap_cnt_d = '0;
        end
      end
      StLoadW, StLoadIp: begin
        if (accept) begin
          // N is a power of two, so the increment wraps N-1 back to 0.
          row_cnt_d = row_cnt_q + row_idx_t'(1);
          if (state_q == StLoadIp) begin
            gap_cnt_d = GapLoad;
          end
          if (row_cnt_q == RowLast) begin
            state_d = (state_q == StLoadW) ? StLoadIp : StWaitOut;
          end
        end
      end
      StWaitOut: begin
        if ((out_cnt_q == OutAll) && drained) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d   = StIdle;
        out_cnt_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q   <= StIdle;
      row_cnt_q <= '0;
      out_cnt_q <= '0;
      gap_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      out_cnt_q <= out_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      err_q     <= err_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign err  = err_q;

  systolic_array_issue_reg u_issue (
    .clk               (clk),
    .nRST              (nRST),
    .beat              (accept),
    .is_weight         (state_q == StLoadW),
    .idx               (row_cnt_q),
    .row               (src.src_row),
    .partial           (src.src_partial),
    .weight_en         (weight_en),
    .input_en          (input_en),
    .partial_en        (partial_en),
    .row_in_en         (row_in_en),
    .row_ps_en         (row_ps_en),
    .array_in          (array_in),
    .array_in_partials (array_in_partials)
  );

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Directed bench for systolic_array_sequencer (N=4, WIDTH=16, ISSUE_GAP=1).
module tb_systolic_array_sequencer;
  import systolic_array_pkg::*;

  logic     tb_clk = 1'b0;
  logic     nRST = 1'b1;
  logic     start = 1'b0;
  logic     load_weights = 1'b0;
  logic     fifo_has_space = 1'b1;
  logic     drained = 1'b0;
  logic     out_en = 1'b0;
  row_idx_t row_out = '0;
  logic     busy, done, err, weight_en, input_en, partial_en;
  row_idx_t row_in_en, row_ps_en;
  row_t     array_in, array_in_partials;

  int tests_run = 0;
  int tests_failed = 0;

  systolic_array_sequencer_if src_if ();

  systolic_array_sequencer #(.ISSUE_GAP(1)) dut (
    .clk               (tb_clk),
    .nRST              (nRST),
    .start             (start),
    .load_weights      (load_weights),
    .busy              (busy),
    .done              (done),
    .err               (err),
    .src               (src_if),
    .weight_en         (weight_en),
    .input_en          (input_en),
    .partial_en        (partial_en),
    .row_in_en         (row_in_en),
    .row_ps_en         (row_ps_en),
    .array_in          (array_in),
    .array_in_partials (array_in_partials),
    .fifo_has_space    (fifo_has_space),
    .drained           (drained),
    .out_en            (out_en),
    .row_out           (row_out)
  );

  always #5 tb_clk = ~tb_clk;

  typedef struct {
    int       cyc;
    logic     w;
    row_idx_t ri;
    row_idx_t rp;
    logic     pe;
    row_t     a;
    row_t     p;
  } beat_t;

  beat_t log_q[$];
  int    cyc = 0;
  int    done_cnt = 0;
  int    bad_en = 0;
  logic  err_at_done = 1'b0;

  always @(posedge tb_clk) cyc++;

  always @(negedge tb_clk) begin
    if (weight_en || input_en)
      log_q.push_back('{cyc, weight_en, row_in_en, row_ps_en, partial_en, array_in,
                        array_in_partials});
    if ((weight_en && input_en) || (input_en != partial_en)) bad_en++;
    if (done) begin
      done_cnt++;
      err_at_done = err;
    end
  end

  function automatic row_t w_row(int k);
    return {16'hA0A0, 16'hB1B1, 16'hC2C2, 16'(k)};
  endfunction

  function automatic row_t in_row(int s, int k);
    return {16'(s), 16'h1234, 16'h5678, 16'(k + 256)};
  endfunction

  function automatic row_t ps_row(int s, int k);
    return ~in_row(s, k);
  endfunction

  // Present one row and hold it until accepted (bounded).
  task automatic send(input row_t r, input row_t p, output bit ok);
    int t;
    t = 0;
    ok = 1'b0;
    src_if.src_valid = 1'b1;
    src_if.src_row = r;
    src_if.src_partial = p;
    while (!ok && t < 50) begin
      @(negedge tb_clk);
      ok = src_if.src_ready;
      @(posedge tb_clk);
      #1;
      t++;
    end
    src_if.src_valid = 1'b0;
  endtask

  // Runs one complete job; no checks here, observations are handed back.
  task automatic drive_job(input bit lw, input int stall_after, input bit ooo, input bit spur,
                           input int seed, output bit ok, output bit stall_ready,
                           output logic [3:0] err_tr, output logic err_start);
    bit acc;
    int ord[4];
    int t;
    int d0;
    d0 = done_cnt;
    ok = 1'b1;
    stall_ready = 1'b0;
    err_tr = '0;
    if (ooo) ord = '{0, 2, 1, 3};
    else ord = '{0, 1, 2, 3};
    start = 1'b1;
    load_weights = lw;
    @(posedge tb_clk);
    #1;
    start = 1'b0;
    load_weights = 1'b0;
    err_start = err;
    if (lw) begin
      for (int k = 0; k < N; k++) begin
        send(w_row(k), '1, acc);
        ok &= acc;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (spur && k == 2) start = 1'b1;
      send(in_row(seed, k), ps_row(seed, k), acc);
      ok &= acc;
      start = 1'b0;
      if (k == stall_after && k + 1 < N) begin
        fifo_has_space = 1'b0;
        src_if.src_valid = 1'b1;
        src_if.src_row = in_row(seed, k + 1);
        src_if.src_partial = ps_row(seed, k + 1);
        repeat (5) begin
          @(negedge tb_clk);
          if (src_if.src_ready) stall_ready = 1'b1;
          @(posedge tb_clk);
          #1;
        end
        fifo_has_space = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      out_en = 1'b1;
      row_out = row_idx_t'(ord[j]);
      if (spur && j == 1) start = 1'b1;
      @(posedge tb_clk);
      #1;
      err_tr[j] = err;
      start = 1'b0;
    end
    out_en = 1'b0;
    drained = 1'b1;
    t = 0;
    while (done_cnt == d0 && t < 20) begin
      @(posedge tb_clk);
      #1;
      t++;
    end
    if (done_cnt == d0) ok = 1'b0;
    drained = 1'b0;
    repeat (2) begin
      @(posedge tb_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #2 nRST = 1'b0;
    #11;
    tests_run++;
    if ({busy, done, err, src_if.src_ready, weight_en, input_en, partial_en} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b, expected 0000000",
               {busy, done, err, src_if.src_ready, weight_en, input_en, partial_en});
    end
    tests_run++;
    if ({row_in_en, row_ps_en} !== 4'b0) begin
      tests_failed++;
      $display("FAIL reset_idx: got %h, expected 0", {row_in_en, row_ps_en});
    end
    tests_run++;
    if ({array_in, array_in_partials} !== 128'b0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h, expected 0", {array_in, array_in_partials});
    end
    #9 nRST = 1'b1;
    @(posedge tb_clk);
    #1;
  endtask

  task automatic test_weights_job();
    bit ok, sr;
    logic [3:0] et;
    logic es;
    int d0;
    logic [133:0] got, want;
    log_q.delete();
    d0 = done_cnt;
    drive_job(1'b1, -1, 1'b0, 1'b0, 1, ok, sr, et, es);
    tests_run++;
    if (ok !== 1'b1 || log_q.size() != 8) begin
      tests_failed++;
      $display("FAIL wj_flow: got ok=%0d beats=%0d, expected ok=1 beats=8", ok, log_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        got = {log_q[k].w, log_q[k].ri, log_q[k].rp, log_q[k].pe, log_q[k].a, log_q[k].p};
        if (k < 4) want = {1'b1, row_idx_t'(k), row_idx_t'(0), 1'b0, w_row(k), row_t'(0)};
        else want = {1'b0, row_idx_t'(k - 4), row_idx_t'(k - 4), 1'b1, in_row(1, k - 4),
                     ps_row(1, k - 4)};
        tests_run++;
        if (got !== want) begin
          tests_failed++;
          $display("FAIL wj_beat%0d: got %h, expected %h", k, got, want);
        end
        tests_run++;
        if (log_q[k].cyc - log_q[0].cyc != ((k < 4) ? k : 3 + 1 + 2 * (k - 4))) begin
          tests_failed++;
          $display("FAIL wj_timing%0d: got offset %0d, expected %0d", k,
                   log_q[k].cyc - log_q[0].cyc, (k < 4) ? k : 4 + 2 * (k - 4));
        end
      end
    end
    tests_run++;
    if (done_cnt - d0 != 1 || busy !== 1'b0 || err !== 1'b0 || et !== 4'b0) begin
      tests_failed++;
      $display("FAIL wj_done: got dones=%0d busy=%b err=%b trace=%b, expected 1 0 0 0000",
               done_cnt - d0, busy, err, et);
    end
  endtask

  task automatic test_no_weight();
    bit ok, sr;
    logic [3:0] et;
    logic es;
    int nw;
    logic [133:0] got, want;
    log_q.delete();
    drive_job(1'b0, -1, 1'b0, 1'b0, 2, ok, sr, et, es);
    nw = 0;
    foreach (log_q[i]) if (log_q[i].w) nw++;
    tests_run++;
    if (ok !== 1'b1 || nw != 0 || log_q.size() != 4) begin
      tests_failed++;
      $display("FAIL nw_flow: got ok=%0d weights=%0d beats=%0d, expected 1 0 4", ok, nw,
               log_q.size());
    end else begin
      got = {log_q[0].w, log_q[0].ri, log_q[0].rp, log_q[0].pe, log_q[0].a, log_q[0].p};
      want = {1'b0, 2'd0, 2'd0, 1'b1, in_row(2, 0), ps_row(2, 0)};
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL nw_first: got %h, expected %h", got, want);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok, sr;
    logic [3:0] et;
    logic es;
    log_q.delete();
    drive_job(1'b0, 1, 1'b0, 1'b0, 3, ok, sr, et, es);
    tests_run++;
    if (sr !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_ready: got src_ready seen=%b, expected 0", sr);
    end
    tests_run++;
    if (ok !== 1'b1 || log_q.size() != 4) begin
      tests_failed++;
      $display("FAIL bp_flow: got ok=%0d beats=%0d, expected 1 4", ok, log_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests_run++;
        if ({log_q[k].ri, log_q[k].a} !== {row_idx_t'(k), in_row(3, k)}) begin
          tests_failed++;
          $display("FAIL bp_row%0d: got idx=%0d data=%h, expected idx=%0d data=%h", k,
                   log_q[k].ri, log_q[k].a, k, in_row(3, k));
        end
      end
      tests_run++;
      if (log_q[2].cyc - log_q[1].cyc != 6 || log_q[3].cyc - log_q[2].cyc != 2) begin
        tests_failed++;
        $display("FAIL bp_gap: got %0d/%0d cycles, expected 6/2",
                 log_q[2].cyc - log_q[1].cyc, log_q[3].cyc - log_q[2].cyc);
      end
    end
  endtask

  task automatic test_out_of_order();
    bit ok, sr;
    logic [3:0] et;
    logic es;
    int d0;
    d0 = done_cnt;
    drive_job(1'b0, -1, 1'b1, 1'b0, 4, ok, sr, et, es);
    tests_run++;
    if (et !== 4'b1110) begin
      tests_failed++;
      $display("FAIL ooo_trace: got err trace %b, expected 1110", et);
    end
    tests_run++;
    if (ok !== 1'b1 || err_at_done !== 1'b1 || done_cnt - d0 != 1) begin
      tests_failed++;
      $display("FAIL ooo_done: got ok=%0d err@done=%b dones=%0d, expected 1 1 1", ok,
               err_at_done, done_cnt - d0);
    end
    drive_job(1'b0, -1, 1'b0, 1'b0, 5, ok, sr, et, es);
    tests_run++;
    if (es !== 1'b0 || err_at_done !== 1'b0 || et !== 4'b0) begin
      tests_failed++;
      $display("FAIL ooo_clear: got err@start=%b err@done=%b trace=%b, expected 0 0 0000", es,
               err_at_done, et);
    end
  endtask

  task automatic test_async_reset();
    bit acc, acc2, ok, sr;
    logic [3:0] et;
    logic es;
    int d0;
    d0 = done_cnt;
    start = 1'b1;
    @(posedge tb_clk);
    #1;
    start = 1'b0;
    send(in_row(7, 0), ps_row(7, 0), acc);
    send(in_row(7, 1), ps_row(7, 1), acc2);
    tests_run++;
    if ({acc, acc2, input_en, row_in_en} !== {1'b1, 1'b1, 1'b1, 2'd1}) begin
      tests_failed++;
      $display("FAIL ar_pre: got %b, expected 11101", {acc, acc2, input_en, row_in_en});
    end
    #2 nRST = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, err, src_if.src_ready, weight_en, input_en, partial_en, row_in_en,
         row_ps_en} !== 11'b0) begin
      tests_failed++;
      $display("FAIL ar_ctrl: got %b, expected 0", {busy, done, err, src_if.src_ready,
               weight_en, input_en, partial_en, row_in_en, row_ps_en});
    end
    tests_run++;
    if ({array_in, array_in_partials} !== 128'b0) begin
      tests_failed++;
      $display("FAIL ar_data: got %h, expected 0", {array_in, array_in_partials});
    end
    #3 nRST = 1'b1;
    @(posedge tb_clk);
    #1;
    tests_run++;
    if (done_cnt != d0) begin
      tests_failed++;
      $display("FAIL ar_nodone: got %0d dones, expected 0", done_cnt - d0);
    end
    log_q.delete();
    drive_job(1'b0, -1, 1'b0, 1'b0, 8, ok, sr, et, es);
    tests_run++;
    if (ok !== 1'b1 || log_q.size() != 4 || done_cnt - d0 != 1) begin
      tests_failed++;
      $display("FAIL ar_rerun: got ok=%0d beats=%0d dones=%0d, expected 1 4 1", ok,
               log_q.size(), done_cnt - d0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests_run++;
        if ({log_q[k].ri, log_q[k].rp, log_q[k].a} !== {row_idx_t'(k), row_idx_t'(k),
             in_row(8, k)}) begin
          tests_failed++;
          $display("FAIL ar_row%0d: got idx=%0d/%0d, expected %0d", k, log_q[k].ri,
                   log_q[k].rp, k);
        end
      end
    end
  endtask

  task automatic test_ignored_start();
    bit ok, sr;
    logic [3:0] et;
    logic es;
    int d0;
    d0 = done_cnt;
    log_q.delete();
    drive_job(1'b0, -1, 1'b0, 1'b1, 9, ok, sr, et, es);
    repeat (5) begin
      @(posedge tb_clk);
      #1;
    end
    tests_run++;
    if (ok !== 1'b1 || done_cnt - d0 != 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ig_done: got ok=%0d dones=%0d busy=%b, expected 1 1 0", ok,
               done_cnt - d0, busy);
    end
    tests_run++;
    if (log_q.size() != 4) begin
      tests_failed++;
      $display("FAIL ig_beats: got %0d beats, expected 4", log_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests_run++;
        if (log_q[k].ri !== row_idx_t'(k)) begin
          tests_failed++;
          $display("FAIL ig_row%0d: got idx=%0d, expected %0d", k, log_q[k].ri, k);
        end
      end
    end
    tests_run++;
    if (bad_en != 0) begin
      tests_failed++;
      $display("FAIL enable_pairing: got %0d bad cycles, expected 0", bad_en);
    end
  endtask

  initial begin
    src_if.src_valid = 1'b0;
    src_if.src_row = '0;
    src_if.src_partial = '0;
    test_reset();
    test_weights_job();
    test_no_weight();
    test_backpressure();
    test_out_of_order();
    test_async_reset();
    test_ignored_start();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
